// File: rtl/mfp_buzzer_ctrl_pkg.sv
// Shared constants and types for the mfp_buzzer_ctrl tone generator.
// Optional build macro MFP_BUZZ_PWM_MIX_EN selects the PWM mixer in the top level.
package mfp_buzzer_ctrl_pkg;

  localparam int unsigned DefTickDiv = 50000;

  // Per-channel register offsets, low two address bits
  localparam logic [1:0] RegHalfPeriod = 2'd0;
  localparam logic [1:0] RegDuration   = 2'd1;
  localparam logic [1:0] RegCtrl       = 2'd2;
  localparam logic [1:0] RegStatus     = 2'd3;

  typedef enum logic {
    StIdle = 1'b0,
    StPlay = 1'b1
  } ch_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mfp_buzzer_ctrl_channel.sv
// One tone channel: IDLE/PLAY FSM, half-period counter, duration counter and tone flop.
// expire is a combinational pulse on the edge that ends a timed note.
module mfp_buzzer_ctrl_channel
  import mfp_buzzer_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 20,
  parameter int unsigned DUR_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_period,
  input  logic [DUR_W-1:0] duration,
  output logic             tone,
  output logic             busy,
  output logic             expire,
  output logic [DUR_W-1:0] dur_cnt
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             tone_q, tone_d;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StIdle;
      half_q  <= '0;
      dur_q   <= '0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    expire  = 1'b0;
    // Start wins over everything, including a coincident expiry
    if (start) begin
      state_d = StPlay;
      half_d  = (half_period == '0) ? '0 : half_period - CNT_W'(1);
      dur_d   = duration;
      tone_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPlay: begin
          if (stop) begin
            state_d = StIdle;
            half_d  = '0;
            dur_d   = '0;
            tone_d  = 1'b0;
          end else begin
            // A rest parks the counter at 0 so a new pitch toggles at once
            if (half_period == '0) begin
              tone_d = 1'b0;
              half_d = '0;
            end else if (half_q == '0) begin
              tone_d = ~tone_q;
              half_d = half_period - CNT_W'(1);
            end else begin
              half_d = half_q - CNT_W'(1);
            end
            if (tick && (dur_q != '0)) begin
              if (dur_q == DUR_W'(1)) begin
                state_d = StIdle;
                dur_d   = '0;
                tone_d  = 1'b0;
                expire  = 1'b1;
              end else begin
                dur_d = dur_q - DUR_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tone    = tone_q;
  assign busy    = (state_q == StPlay);
  assign dur_cnt = dur_q;

endmodule

// File: rtl/mfp_buzzer_ctrl.sv
// Multi-channel buzzer: shared ms prescaler, register port, N_CH tone channels and a pin mixer.
// Define MFP_BUZZ_PWM_MIX_EN for proportional PWM mixing instead of the OR mix.
module mfp_buzzer_ctrl
  import mfp_buzzer_ctrl_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned TICK_DIV = DefTickDiv,
  localparam int unsigned AW      = $clog2(N_CH) + 2
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [31:0]     wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [31:0]     rd_data,
  output logic [N_CH-1:0] tone_out,
  output logic [N_CH-1:0] busy,
  output logic            done_irq,
  output logic            buzz_out
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  logic [AW-1:0] wr_ch, rd_ch;
  logic          wr_ok, rd_ok;
  logic [CW-1:0] wr_idx, rd_idx;
  logic          unused_wdata;

  assign wr_ch        = wr_addr >> 2;
  assign rd_ch        = rd_addr >> 2;
  assign wr_ok        = (wr_ch < AW'(N_CH));
  assign rd_ok        = (rd_ch < AW'(N_CH));
  assign wr_idx       = CW'(wr_ch);
  assign rd_idx       = CW'(rd_ch);
  assign unused_wdata = ^wr_data;

  logic [N_CH-1:0][CNT_W-1:0] hp_all;
  logic [N_CH-1:0][DUR_W-1:0] dur_all;
  logic [N_CH-1:0][DUR_W-1:0] dur_cnt_all;
  logic [N_CH-1:0]            expire;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic             sel;
    logic [CNT_W-1:0] hp_q;
    logic [DUR_W-1:0] dur_q;

    assign sel = wr_en & wr_ok & (wr_idx == CW'(c));

    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        hp_q  <= '0;
        dur_q <= '0;
      end else begin
        if (sel && (wr_addr[1:0] == RegHalfPeriod)) hp_q <= wr_data[CNT_W-1:0];
        if (sel && (wr_addr[1:0] == RegDuration))   dur_q <= wr_data[DUR_W-1:0];
      end
    end

    assign hp_all[c]  = hp_q;
    assign dur_all[c] = dur_q;

    mfp_buzzer_ctrl_channel #(
      .CNT_W (CNT_W),
      .DUR_W (DUR_W)
    ) u_channel (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .tick        (tick),
      .start       (sel && (wr_addr[1:0] == RegCtrl) && wr_data[0]),
      .stop        (sel && (wr_addr[1:0] == RegCtrl) && !wr_data[0]),
      .half_period (hp_q),
      .duration    (dur_q),
      .tone        (tone_out[c]),
      .busy        (busy[c]),
      .expire      (expire[c]),
      .dur_cnt     (dur_cnt_all[c])
    );
  end

  // CTRL is write-only and reads back as 0
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      case (rd_addr[1:0])
        RegHalfPeriod: rd_data[CNT_W-1:0] = hp_all[rd_idx];
        RegDuration:   rd_data[DUR_W-1:0] = dur_all[rd_idx];
        RegStatus:     rd_data[DUR_W:0]   = {dur_cnt_all[rd_idx], busy[rd_idx]};
        default:       rd_data = '0;
      endcase
    end
  end

  logic done_q, buzz_q, buzz_d;

`ifdef MFP_BUZZ_PWM_MIX_EN
  logic [CW-1:0] pwm_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= (pwm_q == CW'(N_CH - 1)) ? '0 : pwm_q + CW'(1);
    end
  end

  always_comb begin
    buzz_d = (4'(pwm_q) < popcount8(8'(tone_out)));
  end
`else
  always_comb begin
    buzz_d = |tone_out;
  end
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      done_q <= 1'b0;
      buzz_q <= 1'b0;
    end else begin
      done_q <= |expire;
      buzz_q <= buzz_d;
    end
  end

  assign done_irq = done_q;
  assign buzz_out = buzz_q;

endmodule

// File: tb/tb_mfp_buzzer_ctrl.sv
// Bench for mfp_buzzer_ctrl: register table, directed note sequences, and random traffic
// checked every cycle against a timestamp-based behavioural model.
module tb_mfp_buzzer_ctrl;

  localparam int N  = 4;
  localparam int CW = 20;
  localparam int DW = 16;
  localparam int TD = 10;
  localparam int AW = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  logic [N-1:0]  tone_out, busy;
  logic          done_irq, buzz_out;

  always #5 HCLK = ~HCLK;

  mfp_buzzer_ctrl #(
    .N_CH     (N),
    .CNT_W    (CW),
    .DUR_W    (DW),
    .TICK_DIV (TD)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tone_out (tone_out),
    .busy     (busy),
    .done_irq (done_irq),
    .buzz_out (buzz_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: absolute edge index, toggle timestamps, remaining ticks.
  int m_e;
  int m_ticks;
  bit m_play [N];
  bit m_tone [N];
  int m_next [N];
  int m_rem  [N];
  int m_hp   [N];
  int m_dur  [N];
  bit m_done, m_buzz;

  function automatic void m_reset();
    m_e = 0; m_ticks = 0; m_done = 0; m_buzz = 0;
    for (int c = 0; c < N; c++) begin
      m_play[c] = 0; m_tone[c] = 0; m_next[c] = 0; m_rem[c] = 0; m_hp[c] = 0; m_dur[c] = 0;
    end
  endfunction

  function automatic void m_step();
    bit tick = ((m_e % TD) == TD - 1);
    int ch = int'(wr_addr) >> 2;
    int rg = int'(wr_addr) & 3;
    bit any_exp = 0;
    int pc = 0;
    for (int c = 0; c < N; c++) pc += int'(m_tone[c]);
`ifdef MFP_BUZZ_PWM_MIX_EN
    m_buzz = ((m_e % N) < pc);
`else
    m_buzz = (pc != 0);
`endif
    for (int c = 0; c < N; c++) begin
      bit hit = wr_en && (ch == c) && (rg == 2);
      if (hit && wr_data[0]) begin
        m_play[c] = 1; m_tone[c] = 0; m_rem[c] = m_dur[c];
        m_next[c] = m_e + ((m_hp[c] == 0) ? 1 : m_hp[c]);
      end else if (m_play[c] && hit) begin
        m_play[c] = 0; m_tone[c] = 0; m_rem[c] = 0;
      end else if (m_play[c]) begin
        if (m_hp[c] == 0) begin
          m_tone[c] = 0; m_next[c] = m_e + 1;
        end else if (m_e == m_next[c]) begin
          m_tone[c] = !m_tone[c]; m_next[c] = m_e + m_hp[c];
        end
        if (tick && m_rem[c] != 0) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_play[c] = 0; m_tone[c] = 0; any_exp = 1;
          end
        end
      end
    end
    if (wr_en && rg == 0) m_hp[ch] = int'(wr_data[CW-1:0]);
    if (wr_en && rg == 1) m_dur[ch] = int'(wr_data[DW-1:0]);
    m_done = any_exp;
    if (tick) m_ticks++;
    m_e++;
  endfunction

  function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
    int c = int'(a) >> 2;
    case (a[1:0])
      2'd0:    return 32'(m_hp[c]);
      2'd1:    return 32'(m_dur[c]);
      2'd2:    return 32'd0;
      default: return (32'(m_rem[c]) << 1) | 32'(m_play[c]);
    endcase
  endfunction

  initial begin : model
    m_reset();
    forever begin
      @(posedge HCLK or posedge HRESET);
      if (HRESET) m_reset();
      else m_step();
    end
  end

  initial begin : lockstep
    logic [N-1:0] et, eb;
    forever begin
      @(negedge HCLK);
      for (int c = 0; c < N; c++) begin
        et[c] = m_tone[c];
        eb[c] = m_play[c];
      end
      chk("tone_out", 32'(tone_out), 32'(et));
      chk("busy", 32'(busy), 32'(eb));
      chk("done_irq", 32'(done_irq), 32'(m_done));
      chk("buzz_out", 32'(buzz_out), 32'(m_buzz));
      chk("rd_data", rd_data, m_rd(rd_addr));
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    @(posedge HCLK); #1;
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    @(posedge HCLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge HCLK);
      if (done_irq) begin
        seen = 1;
        break;
      end
    end
  endtask

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   t0, first, second;
  bit   prev, seen;

  initial begin : stim
    vecs[0] = '{0,  32'h0000_0005, 32'h0000_0005};
    vecs[1] = '{1,  32'h0001_2345, 32'h0000_2345};
    vecs[2] = '{4,  32'hFFFF_FFFF, 32'h000F_FFFF};
    vecs[3] = '{9,  32'h0000_0007, 32'h0000_0007};
    vecs[4] = '{3,  32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5] = '{15, 32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{14, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{13, 32'hABCD_0000, 32'h0000_0000};

    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    for (int a = 0; a < 16; a++) begin
      @(posedge HCLK); #1 rd_addr = a[AW-1:0];
      #1 chk("reset_rd", rd_data, 32'd0);
    end
    chk("reset_outs", {tone_out, busy, done_irq, buzz_out}, 32'd0);

    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].data);
      rd_addr = vecs[i].addr[AW-1:0];
      #1 chk($sformatf("table%0d", i), rd_data, vecs[i].exp);
    end

    // Reset mid-play
    wr(0, 3); wr(1, 0); wr(2, 1);
    repeat (5) @(posedge HCLK);
    #3 chk("t1_busy_before", 32'(busy[0]), 32'd1);
    HRESET = 1'b1;
    #1 chk("t1_async", {tone_out, busy, done_irq, buzz_out}, 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      chk("t1_after", {tone_out, busy, done_irq, buzz_out}, 32'd0);
    end

    // Free-running tone, then stop
    wr(0, 3); wr(1, 0); wr(2, 1);
    first = -1; second = -1; prev = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge HCLK);
      if (tone_out[0] && !prev) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      prev = tone_out[0];
    end
    chk("t2_first_rise", 32'(first), 32'd4);
    chk("t2_period", 32'(second - first), 32'd6);
    wr(2, 0);
    @(negedge HCLK);
    chk("t2_stop_busy", 32'(busy[0]), 32'd0);
    repeat (4) begin
      @(negedge HCLK);
      chk("t2_no_done", 32'(done_irq), 32'd0);
    end

    // Timed note expiry
    wr(4, 2); wr(5, 4); wr(6, 1);
    t0 = m_ticks;
    wait_done(100, seen);
    chk("t3_done_seen", 32'(seen), 32'd1);
    chk("t3_ticks", 32'(m_ticks - t0), 32'd4);
    chk("t3_busy", 32'(busy[1]), 32'd0);
    #1 rd_addr = 4'd7;
    #1 chk("t3_status", rd_data, 32'd0);
    @(negedge HCLK);
    chk("t3_pulse_len", 32'(done_irq), 32'd0);

    // Rest note, then stop on the expiry edge
    wr(8, 0); wr(9, 2); wr(10, 1);
    t0 = m_ticks;
    wait_done(60, seen);
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_ticks", 32'(m_ticks - t0), 32'd2);
    wr(10, 1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge HCLK); #1;
      if (m_rem[2] == 1 && (m_e % TD) == TD - 1) begin
        seen = 1;
        break;
      end
    end
    chk("t4_found_expiry", 32'(seen), 32'd1);
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 32'd0;
    @(posedge HCLK); #1 wr_en = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      chk("t4_stop_no_done", 32'(done_irq), 32'd0);
      chk("t4_stop_busy", 32'(busy[2]), 32'd0);
    end

    // Restart extends the note
    wr(0, 2); wr(1, 5); wr(2, 1);
    t0 = m_ticks;
    for (int i = 0; i < 100 && (m_ticks - t0) < 3; i++) begin
      @(posedge HCLK); #1;
    end
    wr(2, 1);
    wait_done(120, seen);
    chk("t5_done_seen", 32'(seen), 32'd1);
    chk("t5_ticks", 32'(m_ticks - t0), 32'd8);
    @(negedge HCLK);
    chk("t5_single_pulse", 32'(done_irq), 32'd0);

    // Two-channel mix
    wr(0, 2); wr(1, 0); wr(4, 3); wr(5, 0); wr(2, 1); wr(6, 1);
    repeat (40) @(posedge HCLK);
    wr(2, 0); wr(6, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      @(posedge HCLK); #1;
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      case (wr_addr[1:0])
        2'd0:    wr_data = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 4));
        2'd1:    wr_data = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: wr_data = $urandom;
      endcase
      rd_addr = AW'($urandom_range(0, 15));
    end
    @(posedge HCLK); #1 wr_en = 1'b0;
    repeat (5) @(posedge HCLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
